// File: rtl/overcooked_input_pkg.sv
// Shared definitions for the button conditioning path: channel indices,
// 25 MHz timing defaults and the auto-repeat state encoding.
package overcooked_input_pkg;

    localparam int BTN_CHOP    = 0;
    localparam int BTN_LEFT    = 1;
    localparam int BTN_RIGHT   = 2;
    localparam int BTN_UP      = 3;
    localparam int BTN_DOWN    = 4;
    localparam int NUM_BUTTONS = 5;

    // 40 ms settle, 0.5 s first repeat, 100 ms repeat period at 25 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY    = 12_500_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 2_500_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RPT  = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton: two-flop synchroniser, stable-window debounce, registered
// press/release pulses and an auto-repeat pulse train while held.
module button_channel
    import overcooked_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic noisy_in,
    input  logic repeat_en,
    output logic clean_out,
    output logic press_out,
    output logic release_out,
    output logic repeat_out
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_reg;
    logic          cand_reg;
    logic          cand_next;
    logic [DW-1:0] dcnt_reg;
    logic [DW-1:0] dcnt_next;
    logic          clean_reg;
    logic          clean_next;
    logic          press_reg;
    logic          release_reg;
    logic          repeat_reg;
    logic [RW-1:0] rcnt_reg;
    rpt_state_t    state_reg;

    logic s;
    logic clean_rise;
    logic clean_fall;

    assign s = sync_reg[1];

    // Counter holds at its last value once the window is satisfied
    always_comb begin
        cand_next  = cand_reg;
        dcnt_next  = dcnt_reg;
        clean_next = clean_reg;
        if (s != cand_reg) begin
            cand_next = s;
            dcnt_next = '0;
        end else if (dcnt_reg == DCNT_LAST) begin
            clean_next = cand_reg;
        end else begin
            dcnt_next = dcnt_reg + 1'b1;
        end
    end

    // Edges are taken from the next-state value so pulses line up with clean_out
    assign clean_rise = clean_next & ~clean_reg;
    assign clean_fall = ~clean_next & clean_reg;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_reg    <= '0;
            cand_reg    <= 1'b0;
            dcnt_reg    <= '0;
            clean_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], noisy_in};
            cand_reg    <= cand_next;
            dcnt_reg    <= dcnt_next;
            clean_reg   <= clean_next;
            press_reg   <= clean_rise;
            release_reg <= clean_fall;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_reg  <= IDLE;
            rcnt_reg   <= '0;
            repeat_reg <= 1'b0;
        end else begin
            repeat_reg <= 1'b0;
            if (clean_fall || !repeat_en) begin
                // Abort wins over a pulse that would have fired this cycle
                state_reg <= IDLE;
                rcnt_reg  <= '0;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        rcnt_reg <= '0;
                        if (clean_rise) begin
                            state_reg <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (rcnt_reg == DELAY_LAST) begin
                            repeat_reg <= 1'b1;
                            rcnt_reg   <= '0;
                            state_reg  <= RPT;
                        end else begin
                            rcnt_reg <= rcnt_reg + 1'b1;
                        end
                    end
                    RPT: begin
                        if (rcnt_reg == PERIOD_LAST) begin
                            repeat_reg <= 1'b1;
                            rcnt_reg   <= '0;
                        end else begin
                            rcnt_reg <= rcnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        rcnt_reg  <= '0;
                    end
                endcase
            end
        end
    end

    assign clean_out   = clean_reg;
    assign press_out   = press_reg;
    assign release_out = release_reg;
    assign repeat_out  = repeat_reg;

endmodule

// File: rtl/button_bank.sv
// Bank of independent button conditioners feeding game_logic; one
// button_channel per input bit.
module button_bank
    import overcooked_input_pkg::*;
#(
    parameter int NUM_CH          = NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic [NUM_CH-1:0] noisy_in,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] clean_out,
    output logic [NUM_CH-1:0] press_out,
    output logic [NUM_CH-1:0] release_out,
    output logic [NUM_CH-1:0] repeat_out
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_channel (
            .clock_in   (clock_in),
            .reset_in   (reset_in),
            .noisy_in   (noisy_in[gi]),
            .repeat_en  (repeat_en[gi]),
            .clean_out  (clean_out[gi]),
            .press_out  (press_out[gi]),
            .release_out(release_out[gi]),
            .repeat_out (repeat_out[gi])
        );
    end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with short debounce/repeat windows.
module tb_button_bank;

    localparam int NCH = 2;

    logic           clock_in = 1'b0;
    logic           reset_in;
    logic [NCH-1:0] noisy_in;
    logic [NCH-1:0] repeat_en;
    logic [NCH-1:0] clean_out;
    logic [NCH-1:0] press_out;
    logic [NCH-1:0] release_out;
    logic [NCH-1:0] repeat_out;

    int checks = 0;
    int errors = 0;

    always #5 clock_in = ~clock_in;

    button_bank #(
        .NUM_CH         (NCH),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .noisy_in   (noisy_in),
        .repeat_en  (repeat_en),
        .clean_out  (clean_out),
        .press_out  (press_out),
        .release_out(release_out),
        .repeat_out (repeat_out)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] c, input logic [1:0] p,
                           input logic [1:0] r, input logic [1:0] rp);
        chk({tag, " clean"},   clean_out,   c);
        chk({tag, " press"},   press_out,   p);
        chk({tag, " release"}, release_out, r);
        chk({tag, " repeat"},  repeat_out,  rp);
    endtask

    // Inputs changed right after a call are sampled at the following edge
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic release_all(input string tag, input logic [1:0] prev);
        noisy_in = 2'b00;
        for (int e = 0; e <= 7; e++) begin
            tick();
            chk_all($sformatf("%s e%0d", tag, e), (e >= 6) ? 2'b00 : prev,
                    2'b00, (e == 6) ? prev : 2'b00, 2'b00);
        end
    endtask

    bit gl [18] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 1};

    initial begin
        reset_in  = 1'b0;
        noisy_in  = 2'b11;
        repeat_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("reset c%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);
        end
        noisy_in  = 2'b00;
        repeat_en = 2'b00;
        reset_in  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("idle c%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);
        end
        $display("phase reset: checks=%0d", checks);

        // 1: step on ch0, press 6 edges later
        noisy_in = 2'b01;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk_all($sformatf("t1 e%0d", e), {1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, 2'b00);
        end
        $display("phase 1: checks=%0d", checks);

        // 2: short low glitches never reach clean_out
        for (int i = 0; i < 26; i++) begin
            noisy_in = {1'b0, (i < 18) ? gl[i] : 1'b1};
            tick();
            chk_all($sformatf("t2 c%0d", i), 2'b01, 2'b00, 2'b00, 2'b00);
        end
        $display("phase 2: checks=%0d", checks);
        release_all("t2 rel", 2'b01);

        // 3: repeat train, release lands on a repeat slot at edge 37
        repeat_en = 2'b01;
        for (int e = 0; e <= 40; e++) begin
            noisy_in = {1'b0, e < 31};
            tick();
            chk_all($sformatf("t3 e%0d", e),
                    {1'b0, (e >= 6) && (e < 37)},
                    {1'b0, e == 6},
                    {1'b0, e == 37},
                    {1'b0, (e >= 16) && (e < 37) && ((e - 16) % 3 == 0)});
        end
        $display("phase 3: checks=%0d", checks);

        // 4a: held without repeat enable; 4b: enabling while held does nothing
        repeat_en = 2'b00;
        noisy_in  = 2'b01;
        for (int e = 0; e <= 30; e++) begin
            tick();
            chk_all($sformatf("t4a e%0d", e), {1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, 2'b00);
        end
        repeat_en = 2'b01;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk_all($sformatf("t4b c%0d", i), 2'b01, 2'b00, 2'b00, 2'b00);
        end
        repeat_en = 2'b00;
        release_all("t4b rel", 2'b01);

        // 4c: drop enable on the edge where the third repeat would fire
        noisy_in = 2'b01;
        for (int e = 0; e <= 35; e++) begin
            repeat_en = {1'b0, e < 22};
            tick();
            chk_all($sformatf("t4c e%0d", e), {1'b0, e >= 6}, {1'b0, e == 6}, 2'b00,
                    {1'b0, (e == 16) || (e == 19)});
        end
        release_all("t4c rel", 2'b01);
        $display("phase 4: checks=%0d", checks);

        // 5: channels two cycles apart, repeat only on ch1
        repeat_en = 2'b10;
        for (int e = 0; e <= 20; e++) begin
            noisy_in = {e >= 2, 1'b1};
            tick();
            chk_all($sformatf("t5 e%0d", e), {e >= 8, e >= 6}, {e == 8, e == 6}, 2'b00,
                    {e == 18, 1'b0});
        end
        repeat_en = 2'b00;
        release_all("t5 rel", 2'b11);
        $display("phase 5: checks=%0d", checks);

        // 6: reset in the middle of WAIT, button still held
        repeat_en = 2'b01;
        noisy_in  = 2'b01;
        for (int e = 0; e <= 12; e++) begin
            tick();
            chk_all($sformatf("t6a e%0d", e), {1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, 2'b00);
        end
        reset_in = 1'b0;
        #1;
        chk_all("t6 async", 2'b00, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("t6 rst c%0d", i), 2'b00, 2'b00, 2'b00, 2'b00);
        end
        reset_in = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            tick();
            chk_all($sformatf("t6b e%0d", e), {1'b0, e >= 6}, {1'b0, e == 6}, 2'b00,
                    {1'b0, (e == 16) || (e == 19)});
        end
        $display("phase 6: checks=%0d", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_bank.md
# button_bank

Parametrised multi-channel pushbutton conditioner that replaces the per-button debounce instances feeding game logic. Each channel:
- synchronises an asynchronous button input;
- debounces it;
- emits a clean level, one-cycle press and release pulses, and an optional auto-repeat pulse train for held direction buttons.

It sits between the board buttons and `game_logic`, in the 25 MHz `clock` domain.

## Interface
Parameters:
- `NUM_CH`, 5, number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before `clean_out` changes (≥1; 40 ms at 25 MHz).
- `REPEAT_DELAY`, 12500000, held cycles after the press pulse before the first repeat pulse (≥1).
- `REPEAT_PERIOD`, 2500000, cycles between subsequent repeat pulses (≥1).

Ports (one clock; reset is asynchronous and active-low):
- `clock_in`  in  1  system clock, all state on rising edge.
- `reset_in`  in  1  asynchronous active-low reset; asserted (0) clears all state immediately.
- `noisy_in`  in  `NUM_CH`  raw button levels, asynchronous, 1 = pressed.
- `repeat_en`  in  `NUM_CH`  per-channel auto-repeat enable, synchronous.
- `clean_out`  out  `NUM_CH`  debounced level.
- `press_out`  out  `NUM_CH`  one-cycle pulse on each 0→1 of `clean_out`.
- `release_out`  out  `NUM_CH`  one-cycle pulse on each 1→0 of `clean_out`.
- `repeat_out`  out  `NUM_CH`  one-cycle auto-repeat pulse while held.

## Operation
Channels are fully independent; nothing below couples channels.

Synchroniser:
- Two flops per channel; the second flop output is `s`.

Debounce:
- Per channel: candidate bit `cand` and counter `dcnt`.
- If `s != cand`: `cand <= s`, `dcnt <= 0`.
- Else if `dcnt == DEBOUNCE_CYCLES-1`: `clean <= cand`.
- Else: `dcnt <= dcnt+1`.
- `dcnt` saturates at `DEBOUNCE_CYCLES-1`. It never wraps.

Edge pulses:
- `press_out` is high for exactly the cycle in which `clean_out` first reads 1.
- `release_out` is high for exactly the cycle in which `clean_out` first reads 0.

Repeat FSM per channel, counter `rcnt`:
- `IDLE`:
  - Entry: `rcnt = 0`.
  - On `clean` rising with `repeat_en = 1` → `WAIT`, `rcnt = 0`.
- `WAIT`:
  - `rcnt` increments each cycle.
  - At `rcnt == REPEAT_DELAY-1`: pulse `repeat_out`, `rcnt <= 0`, → `RPT`.
- `RPT`:
  - `rcnt` increments each cycle.
  - At `rcnt == REPEAT_PERIOD-1`: pulse `repeat_out`, `rcnt <= 0`.
- From any state:
  - `clean` falling or `repeat_en = 0` → `IDLE` in the same cycle.
  - No `repeat_out` is issued in that cycle.
- `repeat_en` rising while already held has no effect until the next press.

Counter widths:
- `dcnt`: `$clog2(DEBOUNCE_CYCLES+1)`.
- `rcnt`: `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`.
- Compares are unsigned. No arithmetic wraps.

Reset:
- All flops go to 0: sync, `cand`, `dcnt`, `clean`, FSM = `IDLE`, `rcnt`.
- All outputs read 0 during reset.
- A button held through reset release produces a normal `press_out` once debounced.
- Reset asserted mid-debounce or mid-repeat aborts immediately, with no pulse emitted.

## Timing
- Latency for a clean step on `noisy_in` sampled at edge t:
  - `clean_out` and `press_out`/`release_out` change at edge t+2+`DEBOUNCE_CYCLES` (2 synchroniser cycles plus the stable window).
- Any toggle inside the window restarts it. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `clean_out`.
- First `repeat_out`: `REPEAT_DELAY` cycles after the `press_out` cycle. Subsequent pulses every `REPEAT_PERIOD` cycles.
- `press_out` and `repeat_out` are never high in the same cycle on one channel.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `overcooked_input_pkg` holds:
  - button index constants: `BTN_CHOP=0`, `BTN_LEFT=1`, `BTN_RIGHT=2`, `BTN_UP=3`, `BTN_DOWN=4`;
  - 25 MHz default cycle constants for the three timing parameters;
  - the repeat state enum `rpt_state_t` {`IDLE`, `WAIT`, `RPT`}.
- One sub-module, `button_channel`: a single-channel sync + debounce + edge + repeat FSM.
- `button_bank` instantiates `NUM_CH` copies in a generate loop.

## Test plan
All scenarios use `NUM_CH=2`, `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.
1. Reset release with `noisy_in=0`, then ch0 steps to 1 at edge 0 → `clean_out[0]`=1 and a single `press_out[0]` pulse at edge 6; `release_out`/`repeat_out` stay 0.
2. ch0 held high with glitches of 1–3 cycles low every 3 cycles → `clean_out[0]` never changes; no pulses.
3. ch0 held 30 cycles after press, `repeat_en[0]=1` → `repeat_out[0]` pulses at press+10, +13, +16, …; stops the cycle `clean_out` falls; one `release_out` pulse.
4. Same hold with `repeat_en[0]=0` → zero repeat pulses. Dropping `repeat_en` mid-`RPT` → no further pulses.
5. ch0 and ch1 pressed 2 cycles apart → independent pulses 2 cycles apart; no cross-channel effect.
6. `reset_in` asserted mid-`WAIT` with the button held, then released → outputs 0 immediately; fresh `press_out` 6 cycles after release; repeat timing restarts from 0.
